// File: rtl/mcdf_formatter.sv
// MCDF formatter: collects words from one arbiter channel into a fixed-length
// packet, requests the output side, then bursts the packet with start/end framing.
module mcdf_formatter #(
  parameter int FIFO_WIDE = 32,
  parameter int MAX_LEN   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fmt_en,
  input  logic [1:0]           fmt_len_sel,
  input  logic                 arb_downlink_ready,
  input  logic [1:0]           arb_ch_chosen,
  input  logic [FIFO_WIDE-1:0] arb_data_in,
  output logic                 fmt_downlink_valid,
  output logic                 fmt_req,
  input  logic                 fmt_grant,
  output logic [1:0]           fmt_chid,
  output logic [5:0]           fmt_length,
  output logic [FIFO_WIDE-1:0] fmt_data,
  output logic                 fmt_start,
  output logic                 fmt_end,
  output logic                 fmt_busy
);

  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, FILL, REQ, SEND} state_t;

  state_t               state;
  logic [5:0]           cnt;
  logic [5:0]           rd_idx;
  logic [5:0]           pkt_len;
  logic [1:0]           pkt_chid;
  logic [FIFO_WIDE-1:0] pkt_buf [MAX_LEN];
  logic                 xfer;

  function automatic logic [5:0] decode_len(input logic [1:0] sel);
    case (sel)
      2'b00:   return 6'd4;
      2'b01:   return 6'd8;
      2'b10:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Acceptance never looks at arb_downlink_ready; reset forces it low.
  always_comb begin
    fmt_downlink_valid = 1'b0;
    case (state)
      IDLE:    fmt_downlink_valid = fmt_en && (arb_ch_chosen != 2'b11);
      FILL:    fmt_downlink_valid = fmt_en && (arb_ch_chosen == pkt_chid);
      default: fmt_downlink_valid = 1'b0;
    endcase
    if (!rst_n) fmt_downlink_valid = 1'b0;
  end

  assign xfer     = fmt_downlink_valid && arb_downlink_ready;
  assign fmt_busy = (state != IDLE);

  // cnt is zero in IDLE, so the first word lands in slot 0.
  always_ff @(posedge clk) begin
    if (xfer) pkt_buf[cnt[AW-1:0]] <= arb_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_idx     <= '0;
      pkt_len    <= '0;
      pkt_chid   <= '0;
      fmt_req    <= 1'b0;
      fmt_chid   <= '0;
      fmt_length <= '0;
      fmt_data   <= '0;
      fmt_start  <= 1'b0;
      fmt_end    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            pkt_chid <= arb_ch_chosen;
            pkt_len  <= decode_len(fmt_len_sel);
            cnt      <= 6'd1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (xfer) begin
            cnt <= cnt + 6'd1;
            if (cnt + 6'd1 == pkt_len) begin
              state      <= REQ;
              fmt_req    <= 1'b1;
              fmt_chid   <= pkt_chid;
              fmt_length <= pkt_len;
            end
          end
        end
        REQ: begin
          if (fmt_grant) begin
            fmt_req   <= 1'b0;
            fmt_data  <= pkt_buf[0];
            fmt_start <= 1'b1;
            fmt_end   <= 1'b0;
            rd_idx    <= 6'd1;
            cnt       <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (rd_idx == pkt_len) begin
            fmt_data   <= '0;
            fmt_start  <= 1'b0;
            fmt_end    <= 1'b0;
            fmt_chid   <= '0;
            fmt_length <= '0;
            rd_idx     <= '0;
            state      <= IDLE;
          end else begin
            fmt_data  <= pkt_buf[rd_idx[AW-1:0]];
            fmt_start <= 1'b0;
            fmt_end   <= (rd_idx == pkt_len - 6'd1);
            rd_idx    <= rd_idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_formatter.sv
// Directed bench for mcdf_formatter: fill, request, burst, gating and reset abort.
module tb_mcdf_formatter;

  logic        clk;
  logic        rst_n;
  logic        fmt_en;
  logic [1:0]  fmt_len_sel;
  logic        arb_downlink_ready;
  logic [1:0]  arb_ch_chosen;
  logic [31:0] arb_data_in;
  logic        fmt_downlink_valid;
  logic        fmt_req;
  logic        fmt_grant;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic [31:0] fmt_data;
  logic        fmt_start;
  logic        fmt_end;
  logic        fmt_busy;

  int total = 0;
  int bad   = 0;

  mcdf_formatter #(.FIFO_WIDE(32), .MAX_LEN(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fmt_en             (fmt_en),
    .fmt_len_sel        (fmt_len_sel),
    .arb_downlink_ready (arb_downlink_ready),
    .arb_ch_chosen      (arb_ch_chosen),
    .arb_data_in        (arb_data_in),
    .fmt_downlink_valid (fmt_downlink_valid),
    .fmt_req            (fmt_req),
    .fmt_grant          (fmt_grant),
    .fmt_chid           (fmt_chid),
    .fmt_length         (fmt_length),
    .fmt_data           (fmt_data),
    .fmt_start          (fmt_start),
    .fmt_end            (fmt_end),
    .fmt_busy           (fmt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".req"},    64'(fmt_req),    64'd0);
    check({tag, ".chid"},   64'(fmt_chid),   64'd0);
    check({tag, ".length"}, 64'(fmt_length), 64'd0);
    check({tag, ".data"},   64'(fmt_data),   64'd0);
    check({tag, ".start"},  64'(fmt_start),  64'd0);
    check({tag, ".end"},    64'(fmt_end),    64'd0);
    check({tag, ".busy"},   64'(fmt_busy),   64'd0);
  endtask

  task automatic fill4(input logic [1:0] ch, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    fmt_len_sel = 2'b00; arb_ch_chosen = ch; arb_downlink_ready = 1'b1;
    arb_data_in = w0; tick();
    arb_data_in = w1; tick();
    arb_data_in = w2; tick();
    arb_data_in = w3; tick();
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
  endtask

  task automatic burst4(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] exp_w [4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    fmt_grant = 1'b1; tick(); fmt_grant = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check({tag, ".data"},  64'(fmt_data),  64'(exp_w[i]));
      check({tag, ".start"}, 64'(fmt_start), 64'(i == 0));
      check({tag, ".end"},   64'(fmt_end),   64'(i == 3));
      tick();
    end
    check_quiet({tag, ".after"});
  endtask

  initial begin
    rst_n = 1'b1; fmt_en = 1'b1; fmt_len_sel = 2'b10; arb_downlink_ready = 1'b1;
    arb_ch_chosen = 2'd1; arb_data_in = 32'hDEAD_BEEF; fmt_grant = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    // 1: reset state with arbitrary inputs
    check_quiet("rst");
    check("rst.valid", 64'(fmt_downlink_valid), 64'd0);
    fmt_grant = 1'b0; arb_downlink_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check_quiet("rst.release");

    // 2: basic 4-word packet on ch1
    fmt_len_sel = 2'b00; arb_ch_chosen = 2'd1; arb_downlink_ready = 1'b1; arb_data_in = 32'd13;
    #1 check("t2.valid_idle", 64'(fmt_downlink_valid), 64'd1);
    tick();
    check("t2.busy", 64'(fmt_busy), 64'd1);
    check("t2.req_early", 64'(fmt_req), 64'd0);
    arb_data_in = 32'd14; tick();
    arb_data_in = 32'd15; tick();
    check("t2.req_3", 64'(fmt_req), 64'd0);
    arb_data_in = 32'd16; tick();
    check("t2.req", 64'(fmt_req), 64'd1);
    check("t2.chid", 64'(fmt_chid), 64'd1);
    check("t2.length", 64'(fmt_length), 64'd4);
    check("t2.valid_req", 64'(fmt_downlink_valid), 64'd0);
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
    fmt_grant = 1'b1; tick(); fmt_grant = 1'b0;
    check("t2.req_drop", 64'(fmt_req), 64'd0);
    check("t2.w0", 64'(fmt_data), 64'd13);
    check("t2.s0", 64'(fmt_start), 64'd1);
    tick(); check("t2.w1", 64'(fmt_data), 64'd14);
    check("t2.s1", 64'(fmt_start), 64'd0);
    tick(); check("t2.w2", 64'(fmt_data), 64'd15);
    tick(); check("t2.w3", 64'(fmt_data), 64'd16);
    check("t2.e3", 64'(fmt_end), 64'd1);
    check("t2.chid_held", 64'(fmt_chid), 64'd1);
    check("t2.len_held", 64'(fmt_length), 64'd4);
    tick(); check_quiet("t2.done");

    // 3: foreign channel mid-fill is refused
    fmt_len_sel = 2'b00; arb_ch_chosen = 2'd0; arb_downlink_ready = 1'b1;
    arb_data_in = 32'd0; tick();
    arb_data_in = 32'd1; tick();
    arb_ch_chosen = 2'd2; arb_data_in = 32'd99;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check("t3.valid_other", 64'(fmt_downlink_valid), 64'd0);
      tick();
    end
    arb_ch_chosen = 2'd0; arb_data_in = 32'd5; tick();
    check("t3.req_3", 64'(fmt_req), 64'd0);
    arb_data_in = 32'd6; tick();
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
    check("t3.req", 64'(fmt_req), 64'd1);
    check("t3.chid", 64'(fmt_chid), 64'd0);
    burst4("t3", 32'd0, 32'd1, 32'd5, 32'd6);

    // 4: grant withheld for 10 cycles while the arbiter keeps offering
    fill4(2'd1, 32'd100, 32'd101, 32'd102, 32'd103);
    arb_ch_chosen = 2'd1; arb_downlink_ready = 1'b1; arb_data_in = 32'd777;
    for (int unsigned i = 0; i < 10; i++) begin
      check("t4.req_hold", 64'(fmt_req), 64'd1);
      check("t4.valid", 64'(fmt_downlink_valid), 64'd0);
      check("t4.data", 64'(fmt_data), 64'd0);
      tick();
    end
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
    burst4("t4", 32'd100, 32'd101, 32'd102, 32'd103);

    // 5: 32-word packet, length select changed mid-fill
    fmt_len_sel = 2'b11; arb_ch_chosen = 2'd2; arb_downlink_ready = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i == 3) fmt_len_sel = 2'b00;
      arb_data_in = 32'(37 + i);
      tick();
      if (i == 3 || i == 30) check("t5.req_early", 64'(fmt_req), 64'd0);
    end
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
    check("t5.req", 64'(fmt_req), 64'd1);
    check("t5.chid", 64'(fmt_chid), 64'd2);
    check("t5.length", 64'(fmt_length), 64'd32);
    fmt_grant = 1'b1; tick(); fmt_grant = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      check("t5.data", 64'(fmt_data), 64'(37 + i));
      check("t5.start", 64'(fmt_start), 64'(i == 0));
      check("t5.end", 64'(fmt_end), 64'(i == 31));
      tick();
    end
    check_quiet("t5.done");

    // 6: gating in IDLE, then fmt_en pause mid-fill
    arb_downlink_ready = 1'b1; arb_ch_chosen = 2'b11; fmt_en = 1'b1; arb_data_in = 32'd55;
    #1 check("t6.valid_nochan", 64'(fmt_downlink_valid), 64'd0);
    tick(); check("t6.busy_nochan", 64'(fmt_busy), 64'd0);
    arb_ch_chosen = 2'd1; fmt_en = 1'b0;
    #1 check("t6.valid_dis", 64'(fmt_downlink_valid), 64'd0);
    tick(); check("t6.busy_dis", 64'(fmt_busy), 64'd0);
    fmt_en = 1'b1; fmt_len_sel = 2'b00;
    arb_data_in = 32'd200; tick();
    arb_data_in = 32'd201; tick();
    fmt_en = 1'b0; arb_data_in = 32'd999;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check("t6.valid_paused", 64'(fmt_downlink_valid), 64'd0);
      tick();
    end
    check("t6.busy_paused", 64'(fmt_busy), 64'd1);
    fmt_en = 1'b1; arb_data_in = 32'd202; tick();
    check("t6.req_3", 64'(fmt_req), 64'd0);
    arb_data_in = 32'd203; tick();
    arb_downlink_ready = 1'b0; arb_ch_chosen = 2'b11;
    check("t6.req", 64'(fmt_req), 64'd1);
    burst4("t6", 32'd200, 32'd201, 32'd202, 32'd203);

    // 1b: asynchronous reset in the middle of a burst
    fill4(2'd0, 32'h11, 32'h12, 32'h13, 32'h14);
    fmt_grant = 1'b1; tick(); fmt_grant = 1'b0;
    tick();
    check("r2.w1", 64'(fmt_data), 64'h12);
    #2 rst_n = 1'b0;
    #1 check_quiet("r2.async");
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_quiet("r2.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcdf_formatter.md
Name: mcdf_formatter

Overview:
- Downstream stage of the MCDF arbiter. Consumes the arbitrated data stream and its channel tag.
- Assembles words from one channel into fixed-length packets in an internal buffer.
- Requests the output side, then bursts each granted packet out with start/end framing.

Parameters:
- FIFO_WIDE, 32, data word width in bits; must match the arbiter's data width.
- MAX_LEN, 32, packet buffer depth in words; equals the largest selectable packet length.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fmt_en  input  1  enables acceptance of new words; does not stop request or send.
- fmt_len_sel  input  2  packet length select: 00→4, 01→8, 10→16, 11→32 words.
- arb_downlink_ready  input  1  arbiter has a valid word on arb_data_in this cycle.
- arb_ch_chosen  input  2  channel ID of the current arbiter word; 2'b11 means no channel.
- arb_data_in  input  FIFO_WIDE  data word from the arbiter.
- fmt_downlink_valid  output  1  formatter accepts a word this cycle (combinational).
- fmt_req  output  1  packet ready; request to the output side.
- fmt_grant  input  1  output side grants the packet.
- fmt_chid  output  2  channel ID of the packet being requested or sent.
- fmt_length  output  6  length of the packet being requested or sent (4/8/16/32).
- fmt_data  output  FIFO_WIDE  packet word.
- fmt_start  output  1  high with the first word of a packet.
- fmt_end  output  1  high with the last word of a packet.
- fmt_busy  output  1  high when state is not IDLE.

Behaviour:
- Transfer rule: a word transfers at a rising edge where fmt_downlink_valid and arb_downlink_ready are both high.
- fmt_downlink_valid depends only on state, fmt_en and arb_ch_chosen. It never depends on arb_downlink_ready.
- Reset (async, immediate):
  - State goes to IDLE; word count, read index, pkt_chid and pkt_len are cleared.
  - All outputs go to 0; buffer contents are discarded.
  - Reset asserted mid-fill or mid-send aborts the packet with no partial output afterwards.
- IDLE:
  - fmt_downlink_valid = fmt_en && (arb_ch_chosen != 2'b11).
  - On a transfer: buf[0] <= data, pkt_chid <= arb_ch_chosen, pkt_len <= decode(fmt_len_sel), cnt <= 1, then go to FILL.
- FILL:
  - fmt_downlink_valid = fmt_en && (arb_ch_chosen == pkt_chid). Words from other channels are never accepted.
  - On a transfer: buf[cnt] <= data, cnt++.
  - When a transfer makes cnt == pkt_len, go to REQ.
  - fmt_en low: acceptance pauses and contents are held; filling resumes when fmt_en returns high.
- REQ:
  - fmt_req=1; fmt_chid=pkt_chid; fmt_length=pkt_len; fmt_downlink_valid=0.
  - Held indefinitely until fmt_grant is sampled high.
  - fmt_grant sampled high at edge k: fmt_req drops at edge k and state goes to SEND.
- SEND:
  - Outputs are registered. Word i is driven after edge k+i, for i = 0 to pkt_len-1.
  - One word per cycle with no backpressure.
  - fmt_start=1 only with word 0; fmt_end=1 only with word pkt_len-1.
  - fmt_chid and fmt_length are held through the burst.
  - At edge k+pkt_len: data, start and end return to 0 and state returns to IDLE; acceptance may resume that cycle.
- Outside REQ, fmt_grant is ignored.
- fmt_len_sel is latched only on the first word; changes mid-packet have no effect.
- fmt_chid and fmt_length read 0 in IDLE and FILL. fmt_data reads 0 when not sending.
- Counters are 6 bits; cnt never exceeds pkt_len and never wraps.

Test Plan:
1. Reset: hold rst_n=0 with arbitrary inputs → all outputs 0, fmt_busy=0. Assert rst_n mid-SEND → outputs 0 within the same cycle, with no clock needed.
2. Basic 4-word packet: fmt_len_sel=00, ch1 presents 13,14,15,16 back-to-back →
   - fmt_req rises the cycle after the 4th transfer, with fmt_chid=1 and fmt_length=4.
   - Grant held 1 cycle → fmt_data 13,14,15,16 on consecutive cycles; fmt_start on 13, fmt_end on 16.
3. Channel switch mid-fill: ch0 words 0,1 accepted, then arb_ch_chosen=2 for 3 cycles → fmt_downlink_valid=0 for those cycles. ch0 resumes with 5,6 → packet is 0,1,5,6 with chid 0.
4. Delayed grant: packet ready, fmt_grant low for 10 cycles → fmt_req stays 1, fmt_downlink_valid stays 0, no fmt_data activity. Grant → burst starts the next cycle.
5. Max length and latching: fmt_len_sel=11, ch2 words 37..68 → fmt_length=32, fmt_end on word 68. fmt_len_sel changed to 00 after the 3rd word → still 32 words.
6. Gating: arb_ch_chosen=11, or fmt_en=0 in IDLE, with arb_downlink_ready=1 → no acceptance, fmt_busy=0. fmt_en low mid-FILL → count frozen; resumes correctly when re-enabled.
